// File: rtl/dmem_pkg.sv
// Shared definitions for the multi-cycle data-memory responder.
package dmem_pkg;

    // Responder FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam int WORD_BYTES    = 4;
    localparam int BYTE_OFS_BITS = 2;
    localparam int CNT_WIDTH     = 4;

    // True when a byte address does not fall on a word boundary.
    function automatic logic is_misaligned(input logic [BYTE_OFS_BITS-1:0] ofs);
        return ofs != '0;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word storage: write enable, registered read, no reset.
module dmem_array #(
    parameter int ADDR_BITS  = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_BITS-1:0]  addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];
    logic [DATA_WIDTH-1:0] rdata_reg;

    // Read-first port: the read register always reflects the addressed word
    // as it was before any write on the same edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata_reg <= mem[addr];
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle responder for the CPU data-memory port: accepts one request,
// completes it a fixed number of edges later and pulses ack for one cycle.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        ack_o,
    output logic        err_o,
    output logic        stall_o
);

    // Byte-address bits that matter; everything above wraps.
    localparam int AW = ADDR_WIDTH + BYTE_OFS_BITS;
    localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(LATENCY);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    state_t                state_reg;
    logic [CNT_WIDTH-1:0]  cnt_reg;
    logic                  we_reg;
    logic [AW-1:0]         addr_reg;
    logic [31:0]           wdata_reg;
    logic [31:0]           rdata_reg;
    logic                  ack_reg;
    logic                  err_reg;

    logic                  access_now;
    logic                  misaligned;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_rdata;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^addr_i[31:AW];

    assign misaligned = is_misaligned(addr_reg[BYTE_OFS_BITS-1:0]);
    assign access_now = (state_reg == BUSY) && (cnt_reg == CNT_ONE);
    assign mem_we     = access_now && we_reg && !misaligned;

    // In IDLE the array is pointed at the incoming address so that even a
    // one-edge latency has the word already in the read register when the
    // access completes; afterwards it follows the latched address.
    always_comb begin
        mem_addr = addr_reg[AW-1:BYTE_OFS_BITS];
        if (state_reg == IDLE) begin
            mem_addr = addr_i[AW-1:BYTE_OFS_BITS];
        end
    end

    dmem_array #(
        .ADDR_BITS  (ADDR_WIDTH),
        .DATA_WIDTH (32)
    ) u_array (
        .clk   (clk_i),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (wdata_reg),
        .rdata (mem_rdata)
    );

    // Request FSM: accept in IDLE, count down in BUSY, pulse ack/err in ACK.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            ack_reg   <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            ack_reg <= 1'b0;
            err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_i) begin
                        we_reg    <= we_i;
                        addr_reg  <= addr_i[AW-1:0];
                        wdata_reg <= wdata_i;
                        cnt_reg   <= CNT_LOAD;
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    cnt_reg <= cnt_reg - CNT_ONE;
                    if (cnt_reg == CNT_ONE) begin
                        state_reg <= ACK;
                        ack_reg   <= 1'b1;
                        err_reg   <= misaligned;
                        if (!we_reg) begin
                            rdata_reg <= misaligned ? 32'h0 : mem_rdata;
                        end
                    end
                end
                ACK: begin
                    // req_i is deliberately ignored here; a held request is
                    // taken on the following IDLE edge.
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign rdata_o = rdata_reg;
    assign ack_o   = ack_reg;
    assign err_o   = err_reg;
    assign stall_o = req_i & ~ack_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus random
// traffic compared against a word-array reference model.
module tb_data_mem_responder;

    localparam int LAT_A = 4;
    localparam int LAT_B = 1;

    logic        clk;
    logic        rst;

    logic        req_a, we_a, ack_a, err_a, stall_a;
    logic [31:0] addr_a, wdata_a, rdata_a;
    logic        req_b, we_b, ack_b, err_b, stall_b;
    logic [31:0] addr_b, wdata_b, rdata_b;

    int checks   = 0;
    int failures = 0;

    // Selected instance for the generic access task.
    int          cur = 0;
    logic        cur_ack, cur_err, cur_stall;
    logic [31:0] cur_rdata;

    assign cur_ack   = (cur == 1) ? ack_b   : ack_a;
    assign cur_err   = (cur == 1) ? err_b   : err_a;
    assign cur_stall = (cur == 1) ? stall_b : stall_a;
    assign cur_rdata = (cur == 1) ? rdata_b : rdata_a;

    data_mem_responder #(.ADDR_WIDTH(8), .LATENCY(LAT_A)) dut_a (
        .clk_i   (clk),
        .rst_i   (rst),
        .req_i   (req_a),
        .we_i    (we_a),
        .addr_i  (addr_a),
        .wdata_i (wdata_a),
        .rdata_o (rdata_a),
        .ack_o   (ack_a),
        .err_o   (err_a),
        .stall_o (stall_a)
    );

    data_mem_responder #(.ADDR_WIDTH(8), .LATENCY(LAT_B)) dut_b (
        .clk_i   (clk),
        .rst_i   (rst),
        .req_i   (req_b),
        .we_i    (we_b),
        .addr_i  (addr_b),
        .wdata_i (wdata_b),
        .rdata_o (rdata_b),
        .ack_o   (ack_b),
        .err_o   (err_b),
        .stall_o (stall_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: 256 words per instance, plus last completed read.
    logic [31:0] model_mem   [2][256];
    bit          model_known [2][256];
    logic [31:0] model_last  [2];
    bit          model_lknown[2];

    function automatic void model_reset_outputs();
        for (int u = 0; u < 2; u++) begin
            model_last[u]   = 32'h0;
            model_lknown[u] = 1'b1;
        end
    endfunction

    // Apply one access to the model; returns rdata expected after it and err.
    function automatic void model_access(input int u, input bit w, input logic [31:0] a,
                                         input logic [31:0] d, output logic [31:0] exp_rd,
                                         output bit exp_err, output bit exp_known);
        int  idx;
        bit  mis;
        idx = int'(a[9:2]);
        mis = (a[1:0] != 2'b00);
        exp_err = mis;
        if (w) begin
            if (!mis) begin
                model_mem[u][idx]   = d;
                model_known[u][idx] = 1'b1;
            end
        end else if (mis) begin
            model_last[u]   = 32'h0;
            model_lknown[u] = 1'b1;
        end else begin
            model_last[u]   = model_mem[u][idx];
            model_lknown[u] = model_known[u][idx];
        end
        exp_rd    = model_last[u];
        exp_known = model_lknown[u];
    endfunction

    // Drive one request on instance u and observe the outcome.
    // lat = edges from accept to ack (-1 on timeout), stall_cnt = cycles with
    // stall high, ack_next = ack in the cycle after ACK, rd_after = rdata then.
    task automatic do_access(input int u, input bit w, input logic [31:0] a,
                             input logic [31:0] d, output logic [31:0] rd,
                             output bit er, output int lat, output int stall_cnt,
                             output logic ack_next, output logic [31:0] rd_after);
        @(negedge clk);
        cur = u;
        if (u == 1) begin req_b = 1'b1; we_b = w; addr_b = a; wdata_b = d; end
        else        begin req_a = 1'b1; we_a = w; addr_a = a; wdata_a = d; end
        #1;
        stall_cnt = cur_stall ? 1 : 0;
        lat = -1;
        rd = 32'hx;
        er = 1'b0;
        @(posedge clk);
        for (int i = 0; i <= 40; i++) begin
            #1;
            if (cur_ack === 1'b1) begin
                lat = i;
                break;
            end
            if (cur_stall === 1'b1) stall_cnt++;
            @(posedge clk);
        end
        if (lat >= 0) begin
            rd = cur_rdata;
            er = cur_err;
            if (cur_stall === 1'b1) stall_cnt++;
        end
        if (u == 1) req_b = 1'b0; else req_a = 1'b0;
        @(posedge clk);
        #1;
        ack_next = cur_ack;
        rd_after = cur_rdata;
        $display("access u=%0d we=%0d addr=%08h wdata=%08h -> lat=%0d rdata=%08h err=%0d stall_cycles=%0d",
                 u, w, a, d, lat, rd, er, stall_cnt);
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({ack_a, err_a, stall_a, rdata_a} !== 35'h0) begin
            failures++;
            $display("FAIL reset_a: ack=%b err=%b stall=%b rdata=%08h, required all 0",
                     ack_a, err_a, stall_a, rdata_a);
        end
        checks++;
        if ({ack_b, err_b, stall_b, rdata_b} !== 35'h0) begin
            failures++;
            $display("FAIL reset_b: ack=%b err=%b stall=%b rdata=%08h, required all 0",
                     ack_b, err_b, stall_b, rdata_b);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset_outputs();
    endtask

    task automatic test_basic_write();
        logic [31:0] rd, rda, er_rd;
        bit er, ek, ee;
        int lat, sc;
        logic an;
        model_access(0, 1'b1, 32'h10, 32'hDEADBEEF, er_rd, ee, ek);
        do_access(0, 1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat, sc, an, rda);
        checks++;
        if (lat !== LAT_A) begin failures++; $display("FAIL basic_write_latency: got %0d, required %0d", lat, LAT_A); end
        checks++;
        if (er !== 1'b0) begin failures++; $display("FAIL basic_write_err: got %b, required 0", er); end
        checks++;
        if (sc !== LAT_A + 1) begin failures++; $display("FAIL basic_write_stall: got %0d cycles, required %0d", sc, LAT_A + 1); end
        checks++;
        if (an !== 1'b0) begin failures++; $display("FAIL basic_write_ack_width: ack after ACK cycle %b, required 0", an); end
    endtask

    task automatic test_read_hold();
        logic [31:0] rd, rda, erd;
        bit er, ek, ee;
        int lat, sc;
        logic an;
        model_access(0, 1'b0, 32'h10, 32'h0, erd, ee, ek);
        do_access(0, 1'b0, 32'h10, 32'h0, rd, er, lat, sc, an, rda);
        checks++;
        if (rd !== erd) begin failures++; $display("FAIL read_after_write: rdata %08h, required %08h", rd, erd); end
        model_access(0, 1'b1, 32'h14, 32'h01020304, erd, ee, ek);
        do_access(0, 1'b1, 32'h14, 32'h01020304, rd, er, lat, sc, an, rda);
        checks++;
        if (rd !== 32'hDEADBEEF || rda !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL rdata_hold: during=%08h after=%08h, required DEADBEEF", rd, rda);
        end
    endtask

    task automatic test_input_change();
        logic [31:0] rd, rda, erd;
        bit er, ek, ee;
        int lat, sc;
        logic an;
        model_access(0, 1'b1, 32'h24, 32'h0BADCAFE, erd, ee, ek);
        do_access(0, 1'b1, 32'h24, 32'h0BADCAFE, rd, er, lat, sc, an, rda);
        model_access(0, 1'b1, 32'h20, 32'h11111111, erd, ee, ek);
        @(negedge clk);
        req_a = 1'b1; we_a = 1'b1; addr_a = 32'h20; wdata_a = 32'h11111111;
        @(posedge clk);
        @(negedge clk);
        req_a = 1'b0; we_a = 1'b0; addr_a = 32'h24; wdata_a = 32'h22222222;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (ack_a === 1'b1) begin lat = i; break; end
        end
        $display("input_change write 0x20 with req dropped -> ack after %0d edges", lat);
        checks++;
        if (lat !== LAT_A) begin failures++; $display("FAIL input_change_ack: ack after %0d edges, required %0d", lat, LAT_A); end
        @(posedge clk);
        model_access(0, 1'b0, 32'h20, 32'h0, erd, ee, ek);
        do_access(0, 1'b0, 32'h20, 32'h0, rd, er, lat, sc, an, rda);
        checks++;
        if (rd !== erd) begin failures++; $display("FAIL input_change_read20: rdata %08h, required %08h", rd, erd); end
        model_access(0, 1'b0, 32'h24, 32'h0, erd, ee, ek);
        do_access(0, 1'b0, 32'h24, 32'h0, rd, er, lat, sc, an, rda);
        checks++;
        if (rd !== erd) begin failures++; $display("FAIL input_change_read24: rdata %08h, required %08h", rd, erd); end
    endtask

    task automatic test_misaligned();
        logic [31:0] rd, rda, erd;
        bit er, ek, ee;
        int lat, sc;
        logic an;
        model_access(0, 1'b1, 32'h13, 32'h77777777, erd, ee, ek);
        do_access(0, 1'b1, 32'h13, 32'h77777777, rd, er, lat, sc, an, rda);
        checks++;
        if (er !== ee || lat !== LAT_A || an !== 1'b0) begin
            failures++;
            $display("FAIL misaligned_write: err=%b lat=%0d ack_next=%b, required err=%b lat=%0d ack_next=0", er, lat, an, ee, LAT_A);
        end
        model_access(0, 1'b0, 32'h10, 32'h0, erd, ee, ek);
        do_access(0, 1'b0, 32'h10, 32'h0, rd, er, lat, sc, an, rda);
        checks++;
        if (rd !== erd || er !== 1'b0) begin failures++; $display("FAIL misaligned_no_write: rdata %08h err=%b, required %08h err=0", rd, er, erd); end
        model_access(0, 1'b0, 32'h11, 32'h0, erd, ee, ek);
        do_access(0, 1'b0, 32'h11, 32'h0, rd, er, lat, sc, an, rda);
        checks++;
        if (rd !== erd || er !== ee) begin failures++; $display("FAIL misaligned_read: rdata %08h err=%b, required %08h err=%b", rd, er, erd, ee); end
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] rd, rda, erd;
        bit er, ek, ee;
        int lat, sc;
        logic an;
        model_access(0, 1'b1, 32'h30, 32'h12345678, erd, ee, ek);
        do_access(0, 1'b1, 32'h30, 32'h12345678, rd, er, lat, sc, an, rda);
        model_access(0, 1'b0, 32'h10, 32'h0, erd, ee, ek);
        do_access(0, 1'b0, 32'h10, 32'h0, rd, er, lat, sc, an, rda);
        @(negedge clk);
        req_a = 1'b1; we_a = 1'b1; addr_a = 32'h30; wdata_a = 32'h5A5A5A5A;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        $display("reset mid-access: ack=%b err=%b rdata=%08h", ack_a, err_a, rdata_a);
        checks++;
        if ({ack_a, err_a, rdata_a} !== 34'h0) begin
            failures++;
            $display("FAIL reset_mid_outputs: ack=%b err=%b rdata=%08h, required all 0", ack_a, err_a, rdata_a);
        end
        req_a = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset_outputs();
        model_access(0, 1'b0, 32'h30, 32'h0, erd, ee, ek);
        do_access(0, 1'b0, 32'h30, 32'h0, rd, er, lat, sc, an, rda);
        checks++;
        if (rd !== erd) begin failures++; $display("FAIL reset_mid_no_write: rdata %08h, required %08h", rd, erd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] erd;
        bit ee, ek;
        int lat1, gap;
        model_access(0, 1'b1, 32'h40, 32'hA5A50F0F, erd, ee, ek);
        model_access(0, 1'b0, 32'h40, 32'h0, erd, ee, ek);
        @(negedge clk);
        req_a = 1'b1; we_a = 1'b1; addr_a = 32'h40; wdata_a = 32'hA5A50F0F;
        lat1 = -1;
        @(posedge clk);
        for (int i = 0; i <= 40; i++) begin
            #1;
            if (ack_a === 1'b1) begin lat1 = i; break; end
            @(posedge clk);
        end
        // Next request presented during ACK, req held high throughout.
        we_a = 1'b0;
        gap = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (ack_a === 1'b1) begin gap = i; break; end
        end
        req_a = 1'b0;
        $display("back_to_back: first lat=%0d gap=%0d rdata=%08h", lat1, gap, rdata_a);
        checks++;
        if (gap !== LAT_A + 2) begin failures++; $display("FAIL back_to_back_gap: got %0d cycles, required %0d", gap, LAT_A + 2); end
        checks++;
        if (rdata_a !== erd) begin failures++; $display("FAIL back_to_back_data: rdata %08h, required %08h", rdata_a, erd); end
        @(posedge clk);
    endtask

    task automatic test_min_latency_wrap();
        logic [31:0] rd, rda, erd;
        bit er, ek, ee;
        int lat, sc;
        logic an;
        model_access(1, 1'b1, 32'h400, 32'hCAFEF00D, erd, ee, ek);
        do_access(1, 1'b1, 32'h400, 32'hCAFEF00D, rd, er, lat, sc, an, rda);
        checks++;
        if (lat !== LAT_B || sc !== LAT_B + 1) begin
            failures++;
            $display("FAIL min_latency: lat=%0d stall=%0d, required lat=%0d stall=%0d", lat, sc, LAT_B, LAT_B + 1);
        end
        model_access(1, 1'b0, 32'h000, 32'h0, erd, ee, ek);
        do_access(1, 1'b0, 32'h000, 32'h0, rd, er, lat, sc, an, rda);
        checks++;
        if (rd !== erd || lat !== LAT_B) begin failures++; $display("FAIL wrap_read: rdata %08h lat=%0d, required %08h lat=%0d", rd, lat, erd, LAT_B); end
    endtask

    task automatic test_random();
        logic [31:0] rd, rda, erd, a, d;
        bit er, ek, ee, w;
        int lat, sc, u, exp_lat;
        logic an;
        for (int n = 0; n < 40; n++) begin
            u = (n % 3 == 2) ? 1 : 0;
            exp_lat = (u == 1) ? LAT_B : LAT_A;
            w = $urandom_range(0, 1);
            a = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2);
            if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
            d = $urandom;
            model_access(u, w, a, d, erd, ee, ek);
            do_access(u, w, a, d, rd, er, lat, sc, an, rda);
            checks++;
            if (lat !== exp_lat || er !== ee || an !== 1'b0) begin
                failures++;
                $display("FAIL random_%0d_ctrl: lat=%0d err=%b ack_next=%b, required lat=%0d err=%b ack_next=0", n, lat, er, an, exp_lat, ee);
            end
            if (ek) begin
                checks++;
                if (rd !== erd || rda !== erd) begin
                    failures++;
                    $display("FAIL random_%0d_rdata: ack=%08h after=%08h, required %08h", n, rd, rda, erd);
                end
            end
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
        req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;
        for (int u = 0; u < 2; u++)
            for (int i = 0; i < 256; i++) begin
                model_mem[u][i]   = 32'h0;
                model_known[u][i] = 1'b0;
            end
        test_reset();
        test_basic_write();
        test_read_hold();
        test_input_change();
        test_misaligned();
        test_reset_mid_access();
        test_back_to_back();
        test_min_latency_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle responder for the CPU's data-memory port. It replaces the zero-latency data memory behind the MEM stage. It accepts one read or write request at a time, completes it after a fixed `LATENCY`, and signals completion with a one-cycle `ack_o`. `stall_o` is provided so the pipeline can freeze PC, IF_ID, ID_EX, EX_MEM and MEM_WB while an access is outstanding.

## Interface
Parameters:
- `ADDR_WIDTH`, 8: word-address bits; storage depth is 2^ADDR_WIDTH 32-bit words.
- `LATENCY`, 4: clock edges from the accepting edge to `ack_o` assertion; legal range is 1..15.

Ports:
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `req_i`  in  1  request valid; level, held by the requester until it sees `ack_o`.
- `we_i`  in  1  1 = write, 0 = read; sampled at accept.
- `addr_i`  in  32  byte address (EX_MEM ALU result); sampled at accept.
- `wdata_i`  in  32  write data (EX_MEM rt data); sampled at accept.
- `rdata_o`  out  32  read data; registered, holds its value until the next completed read.
- `ack_o`  out  1  completion pulse, registered, exactly one cycle wide.
- `err_o`  out  1  misaligned-access flag; pulses together with `ack_o`.
- `stall_o`  out  1  combinational, equal to `req_i & ~ack_o`.

## Operation
- **FSM states:** IDLE, BUSY, ACK.
- **IDLE:**
  - If `req_i`=1 at an edge, the request is accepted.
  - On acceptance, latch `we_i`, `addr_i[ADDR_WIDTH+1:0]` and `wdata_i`.
  - Load `cnt` with `LATENCY` and go to BUSY.
- **BUSY:**
  - `cnt` decrements on each edge.
  - At an edge where `cnt`==1, perform the access and go to ACK.
  - The access is one of:
    - Write: store the latched data to `mem[addr[ADDR_WIDTH+1:2]]`.
    - Read: load `rdata_o` from `mem[...]`.
- **ACK:**
  - `ack_o`=1, plus `err_o` if the access was misaligned.
  - Next edge returns to IDLE unconditionally; `req_i` is not sampled in ACK.
- **Input changes after accept:** all input changes during BUSY/ACK are ignored. Deasserting `req_i` mid-BUSY does not abort the access; `ack_o` still pulses.
- **Misaligned access:** `addr_i[1:0]`≠0.
  - Writes are suppressed and reads return 0.
  - `err_o`=1 during the ACK cycle.
- **Upper address bits:** bits above `ADDR_WIDTH+1` are ignored, so addresses wrap modulo the memory size.
- **Reset values:**
  - On reset, state=IDLE, `cnt`=0, `rdata_o`=0, `ack_o`=0, `err_o`=0.
  - Memory contents are not reset.
  - A reset during BUSY discards the pending access, so no write occurs.

## Timing
- Request accepted at edge E0 → access performed and `ack_o` high in the cycle after edge E0+`LATENCY`.
- `stall_o` is high from the cycle `req_i` rises through the cycle before `ack_o`, and low during the ACK cycle. The pipeline therefore advances on the ACK-cycle edge and captures `rdata_o` there.
- Back-to-back requests:
  - The requester's next `req_i` is seen in IDLE one cycle after ACK.
  - Maximum throughput is one access per `LATENCY`+2 cycles.
- `req_i` asserted during ACK (the new MEM-stage instruction) is accepted on the following IDLE edge.

## Structure
- Shared package `dmem_pkg` holds:
  - the state enum (IDLE, BUSY, ACK);
  - `WORD_BYTES`=4;
  - `BYTE_OFS_BITS`=2;
  - `CNT_WIDTH`=4.
- Sub-module `dmem_array`: a single-port synchronous 32-bit storage array with a write enable, a registered read port and no reset. The FSM, counter, latches and flags live in the top module.

## Test plan
- **Basic write:** reset, `LATENCY`=4, write 0xDEADBEEF to 0x10 → `ack_o` one cycle, 4 edges after accept; `err_o`=0; `stall_o` high for 5 cycles from `req_i` rise.
- **Read-after-write and hold:** read 0x10 → `rdata_o`=0xDEADBEEF in the ACK cycle; `rdata_o` holds through a subsequent write to 0x14.
- **Input change during BUSY:**
  - Write 0x11111111 to 0x20.
  - While BUSY, drop `req_i` and change `addr_i`/`wdata_i` to 0x24/0x22222222.
  - → `ack_o` still pulses; reading 0x20 returns 0x11111111 and reading 0x24 returns the old value.
- **Misaligned write:** write to 0x13 → `err_o`=`ack_o`=1 for one cycle; word 0x10 unchanged (0xDEADBEEF).
- **Reset mid-access:** assert `rst_i` 2 cycles after accepting a write of 0x5A5A5A5A to 0x30 → outputs 0 immediately; reading 0x30 later does not return 0x5A5A5A5A.
- **Minimum latency and wrap:** `LATENCY`=1, `ADDR_WIDTH`=8, write 0xCAFEF00D to byte address 0x400 → ack after 1 edge; reading 0x000 returns 0xCAFEF00D.
